// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, instruction memory and decode.
// master = fetch controller side, slave = memory/decode side.
interface fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage controller: issues instruction reads for the current PC, pairs the
// in-order responses with their PCs in a small buffer and hands them to decode.
// A redirect flushes everything; responses still in flight are counted in a
// drop counter and discarded as they return.
module fetch_ctrl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   i_pc,
    output logic          o_pc_enable,
    output logic [31:0]   o_pc_next,
    input  logic          i_redirect,
    input  logic [31:0]   i_redirect_pc,
    fetch_ctrl_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W+1:0] L_DEPTH = (CNT_W+2)'(DEPTH);

    logic [31:0]      r_pendPc   [DEPTH];
    logic [PTR_W-1:0] r_pendWr;
    logic [PTR_W-1:0] r_pendRd;
    logic [31:0]      r_bufPc    [DEPTH];
    logic [31:0]      r_bufInstr [DEPTH];
    logic [PTR_W-1:0] r_bufWr;
    logic [PTR_W-1:0] r_bufRd;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;

    logic [CNT_W+1:0] w_credit;
    logic             w_reqValid;
    logic             w_reqFire;
    logic             w_rspKeep;
    logic             w_rspDrop;
    logic             w_idValid;
    logic             w_idFire;
    logic [CNT_W-1:0] w_outNext;
    logic [CNT_W-1:0] w_dropNext;
    logic [CNT_W-1:0] w_countNext;

    // Every slot is either in flight (kept or dropped) or buffered, so this sum
    // bounds the buffer and prevents overflow.
    assign w_credit   = (CNT_W+2)'(r_outstanding) + (CNT_W+2)'(r_count) + (CNT_W+2)'(r_drop);
    assign w_reqValid = !reset && !i_redirect && (w_credit < L_DEPTH);
    assign w_reqFire  = w_reqValid && bus.imem_req_ready;
    assign w_rspDrop  = bus.imem_rsp_valid && (r_drop != '0);
    assign w_rspKeep  = bus.imem_rsp_valid && (r_drop == '0);
    assign w_idValid  = (r_count != '0);
    assign w_idFire   = w_idValid && bus.id_ready;

    assign bus.imem_req_valid = w_reqValid;
    assign bus.imem_req_addr  = {i_pc[31:2], 2'b00};
    assign bus.id_valid       = w_idValid;
    assign bus.id_pc          = r_bufPc[r_bufRd];
    assign bus.id_instr       = r_bufInstr[r_bufRd];

    assign o_pc_enable = !reset && (i_redirect || w_reqFire);
    assign o_pc_next   = i_redirect ? i_redirect_pc : (i_pc + 32'd4);

    // Next values of the three counters; a redirect turns every outstanding read
    // into a dropped one, less the response that is discarded in the same cycle.
    always_comb begin
        w_outNext   = r_outstanding;
        w_dropNext  = r_drop;
        w_countNext = r_count;
        if (i_redirect) begin
            w_outNext   = '0;
            w_dropNext  = r_outstanding + r_drop - CNT_W'(bus.imem_rsp_valid);
            w_countNext = '0;
        end else begin
            w_outNext   = r_outstanding + CNT_W'(w_reqFire) - CNT_W'(w_rspKeep);
            w_dropNext  = r_drop - CNT_W'(w_rspDrop);
            w_countNext = r_count + CNT_W'(w_rspKeep) - CNT_W'(w_idFire);
        end
    end

    // Pending-PC queue, instruction buffer and counters; redirect flushes both queues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pendWr      <= '0;
            r_pendRd      <= '0;
            r_bufWr       <= '0;
            r_bufRd       <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_pendPc[k]   <= '0;
                r_bufPc[k]    <= '0;
                r_bufInstr[k] <= '0;
            end
        end else begin
            r_count       <= w_countNext;
            r_outstanding <= w_outNext;
            r_drop        <= w_dropNext;
            if (i_redirect) begin
                r_pendWr <= '0;
                r_pendRd <= '0;
                r_bufWr  <= '0;
                r_bufRd  <= '0;
            end else begin
                if (w_reqFire) begin
                    r_pendPc[r_pendWr] <= i_pc;
                    r_pendWr           <= r_pendWr + PTR_W'(1);
                end
                if (w_rspKeep) begin
                    r_bufPc[r_bufWr]    <= r_pendPc[r_pendRd];
                    r_bufInstr[r_bufWr] <= bus.imem_rsp_data;
                    r_bufWr             <= r_bufWr + PTR_W'(1);
                    r_pendRd            <= r_pendRd + PTR_W'(1);
                end
                if (w_idFire) begin
                    r_bufRd <= r_bufRd + PTR_W'(1);
                end
            end
        end
    end
endmodule
